// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a stable synchronized lock, then releases the
// system reset; retries a bounded number of times and latches a failure flag.
module pll_lock_supervisor #(
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 100000,
   parameter int LOCK_STABLE_CYCLES  = 1000,
   parameter int MAX_RETRIES         = 3
) (
   input  logic                               refclk,
   input  logic                               rst_n,
   input  logic                               pll_locked,
   input  logic                               clear_fail,
   output logic                               pll_rst,
   output logic                               sys_rst_n,
   output logic                               lock_fail,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
   output logic [7:0]                         lock_loss_count,
   output logic [2:0]                         fsm_state
);

   localparam int RW      = $clog2(MAX_RETRIES + 1);
   localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int MAX_CNT = ((MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES) - 1;
   localparam int CW      = $clog2(MAX_CNT + 1);

   localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_PLL_RESET = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABILIZE = 3'd2,
      S_RUN       = 3'd3,
      S_FAIL      = 3'd4
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          sync1;
   logic          lk;

   // pll_locked is asynchronous to refclk; only the second flop is trusted.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         lk    <= 1'b0;
      end else begin
         sync1 <= pll_locked;
         lk    <= sync1;
      end
   end

   assign fsm_state = state;

   // Outputs are assigned on each transition so they move with the state register.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_PLL_RESET;
         cnt             <= '0;
         pll_rst         <= 1'b1;
         sys_rst_n       <= 1'b0;
         lock_fail       <= 1'b0;
         retry_count     <= '0;
         lock_loss_count <= '0;
      end else begin
         case (state)
            S_PLL_RESET: begin
               if (cnt == RST_LAST) begin
                  state   <= S_WAIT_LOCK;
                  cnt     <= '0;
                  pll_rst <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_WAIT_LOCK: begin
               if (lk) begin
                  state <= S_STABILIZE;
                  cnt   <= '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  cnt     <= '0;
                  pll_rst <= 1'b1;
                  if (retry_count == RETRY_MAX) begin
                     state     <= S_FAIL;
                     lock_fail <= 1'b1;
                  end else begin
                     state       <= S_PLL_RESET;
                     retry_count <= retry_count + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_STABILIZE: begin
               if (!lk) begin
                  state <= S_WAIT_LOCK;
                  cnt   <= '0;
               end else if (cnt == STABLE_LAST) begin
                  state       <= S_RUN;
                  cnt         <= '0;
                  sys_rst_n   <= 1'b1;
                  retry_count <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RUN: begin
               if (!lk) begin
                  state       <= S_PLL_RESET;
                  cnt         <= '0;
                  pll_rst     <= 1'b1;
                  sys_rst_n   <= 1'b0;
                  retry_count <= '0;
                  if (lock_loss_count != 8'hFF)
                     lock_loss_count <= lock_loss_count + 8'd1;
               end
            end
            S_FAIL: begin
               if (clear_fail) begin
                  state       <= S_PLL_RESET;
                  cnt         <= '0;
                  lock_fail   <= 1'b0;
                  retry_count <= '0;
               end
            end
            default: begin
               state     <= S_PLL_RESET;
               cnt       <= '0;
               pll_rst   <= 1'b1;
               sys_rst_n <= 1'b0;
               lock_fail <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: edge-numbered steps with hand-computed
// expectations checked through immediate assertions.
module tb_pll_lock_supervisor;

   localparam int RW = 2;
   localparam logic [2:0] ST_PLL_RESET = 3'd0;
   localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
   localparam logic [2:0] ST_STABILIZE = 3'd2;
   localparam logic [2:0] ST_RUN       = 3'd3;
   localparam logic [2:0] ST_FAIL      = 3'd4;

   logic          refclk = 1'b0;
   logic          rst_n;
   logic          pll_locked;
   logic          clear_fail;
   logic          pll_rst;
   logic          sys_rst_n;
   logic          lock_fail;
   logic [RW-1:0] retry_count;
   logic [7:0]    lock_loss_count;
   logic [2:0]    fsm_state;

   int n_checks = 0;
   int n_fail   = 0;
   int ed       = 0;

   pll_lock_supervisor #(
      .PLL_RST_CYCLES      (4),
      .LOCK_TIMEOUT_CYCLES (32),
      .LOCK_STABLE_CYCLES  (8),
      .MAX_RETRIES         (2)
   ) dut (
      .refclk          (refclk),
      .rst_n           (rst_n),
      .pll_locked      (pll_locked),
      .clear_fail      (clear_fail),
      .pll_rst         (pll_rst),
      .sys_rst_n       (sys_rst_n),
      .lock_fail       (lock_fail),
      .retry_count     (retry_count),
      .lock_loss_count (lock_loss_count),
      .fsm_state       (fsm_state)
   );

   always #5 refclk = ~refclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to edge e (counted from reset release) and settle 1 time unit past it.
   task automatic goto_edge(input int e);
      while (ed < e) begin
         @(posedge refclk);
         ed++;
      end
      #1;
   endtask

   task automatic release_reset();
      @(negedge refclk);
      rst_n = 1'b1;
      ed    = 0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_pll_rst"},   32'(pll_rst),         32'd1);
      check({tag, "_sys_rst_n"}, 32'(sys_rst_n),       32'd0);
      check({tag, "_lock_fail"}, 32'(lock_fail),       32'd0);
      check({tag, "_retry"},     32'(retry_count),     32'd0);
      check({tag, "_llc"},       32'(lock_loss_count), 32'd0);
      check({tag, "_state"},     32'(fsm_state),       32'(ST_PLL_RESET));
   endtask

   initial begin
      int b;
      rst_n      = 1'b0;
      pll_locked = 1'b1;
      clear_fail = 1'b0;
      repeat (3) @(posedge refclk);
      #1;
      check_reset_values("por");

      // Lock held high from the start.
      release_reset();
      goto_edge(3);
      check("a_pll_rst_e3", 32'(pll_rst), 32'd1);
      goto_edge(4);
      check("a_pll_rst_e4", 32'(pll_rst), 32'd0);
      check("a_state_e4", 32'(fsm_state), 32'(ST_WAIT_LOCK));
      goto_edge(5);
      check("a_state_e5", 32'(fsm_state), 32'(ST_STABILIZE));
      goto_edge(12);
      check("a_sys_e12", 32'(sys_rst_n), 32'd0);
      goto_edge(13);
      check("a_sys_e13", 32'(sys_rst_n), 32'd1);
      check("a_state_e13", 32'(fsm_state), 32'(ST_RUN));
      check("a_retry_e13", 32'(retry_count), 32'd0);

      // clear_fail outside FAIL has no effect.
      clear_fail = 1'b1;
      goto_edge(14);
      clear_fail = 1'b0;
      check("cf_run_state", 32'(fsm_state), 32'(ST_RUN));
      check("cf_run_sys", 32'(sys_rst_n), 32'd1);
      check("cf_run_fail", 32'(lock_fail), 32'd0);

      // First lock loss in RUN.
      b = ed;
      pll_locked = 1'b0;
      goto_edge(b + 2);
      check("loss_sys_e2", 32'(sys_rst_n), 32'd1);
      goto_edge(b + 3);
      check("loss_sys_e3", 32'(sys_rst_n), 32'd0);
      check("loss_pll_rst_e3", 32'(pll_rst), 32'd1);
      check("loss_llc_e3", 32'(lock_loss_count), 32'd1);
      check("loss_state_e3", 32'(fsm_state), 32'(ST_PLL_RESET));
      pll_locked = 1'b1;
      goto_edge(b + 6);
      check("loss_pll_rst_e6", 32'(pll_rst), 32'd1);
      goto_edge(b + 7);
      check("loss_pll_rst_e7", 32'(pll_rst), 32'd0);
      goto_edge(b + 15);
      check("relock_sys_e15", 32'(sys_rst_n), 32'd0);
      goto_edge(b + 16);
      check("relock_sys_e16", 32'(sys_rst_n), 32'd1);
      check("relock_llc", 32'(lock_loss_count), 32'd1);

      // 254 more losses bring the counter to 255.
      for (int i = 0; i < 254; i++) begin
         b = ed;
         pll_locked = 1'b0;
         goto_edge(b + 3);
         pll_locked = 1'b1;
         goto_edge(b + 16);
      end
      check("sat_llc_255", 32'(lock_loss_count), 32'd255);
      check("sat_state_run", 32'(fsm_state), 32'(ST_RUN));

      // 256th loss must not wrap.
      b = ed;
      pll_locked = 1'b0;
      goto_edge(b + 3);
      check("sat_llc_hold", 32'(lock_loss_count), 32'd255);
      check("sat_state_rst", 32'(fsm_state), 32'(ST_PLL_RESET));
      pll_locked = 1'b1;
      goto_edge(b + 16);
      check("sat_relock_sys", 32'(sys_rst_n), 32'd1);

      // Asynchronous reset in RUN, checked before the next refclk edge.
      rst_n = 1'b0;
      #2;
      check_reset_values("arst_run");

      // One-cycle lk dropout at STABILIZE counter 5.
      release_reset();
      goto_edge(5);
      check("d_state_e5", 32'(fsm_state), 32'(ST_STABILIZE));
      goto_edge(8);
      pll_locked = 1'b0;
      goto_edge(9);
      pll_locked = 1'b1;
      goto_edge(11);
      check("d_state_e11", 32'(fsm_state), 32'(ST_WAIT_LOCK));
      check("d_retry_e11", 32'(retry_count), 32'd0);
      goto_edge(12);
      check("d_state_e12", 32'(fsm_state), 32'(ST_STABILIZE));
      goto_edge(13);
      check("d_sys_e13", 32'(sys_rst_n), 32'd0);

      // Asynchronous reset in STABILIZE.
      goto_edge(14);
      rst_n = 1'b0;
      #2;
      check_reset_values("arst_stab");

      // Lock never arrives: two retries then FAIL.
      pll_locked = 1'b0;
      release_reset();
      goto_edge(35);
      check("t_retry_e35", 32'(retry_count), 32'd0);
      check("t_pll_rst_e35", 32'(pll_rst), 32'd0);
      goto_edge(36);
      check("t_retry_e36", 32'(retry_count), 32'd1);
      check("t_pll_rst_e36", 32'(pll_rst), 32'd1);
      goto_edge(71);
      check("t_retry_e71", 32'(retry_count), 32'd1);
      goto_edge(72);
      check("t_retry_e72", 32'(retry_count), 32'd2);
      goto_edge(107);
      check("t_fail_e107", 32'(lock_fail), 32'd0);
      goto_edge(108);
      check("t_fail_e108", 32'(lock_fail), 32'd1);
      check("t_state_e108", 32'(fsm_state), 32'(ST_FAIL));
      check("t_pll_rst_e108", 32'(pll_rst), 32'd1);
      goto_edge(120);
      check("t_fail_e120", 32'(lock_fail), 32'd1);
      check("t_pll_rst_e120", 32'(pll_rst), 32'd1);
      check("t_sys_e120", 32'(sys_rst_n), 32'd0);

      clear_fail = 1'b1;
      goto_edge(121);
      clear_fail = 1'b0;
      check("c_state_e121", 32'(fsm_state), 32'(ST_PLL_RESET));
      check("c_fail_e121", 32'(lock_fail), 32'd0);
      check("c_retry_e121", 32'(retry_count), 32'd0);
      check("c_pll_rst_e121", 32'(pll_rst), 32'd1);
      goto_edge(124);
      check("c_pll_rst_e124", 32'(pll_rst), 32'd1);
      goto_edge(125);
      check("c_pll_rst_e125", 32'(pll_rst), 32'd0);
      check("c_state_e125", 32'(fsm_state), 32'(ST_WAIT_LOCK));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
